// File: rtl/rv_regfile_sb.sv
// Multi-port register file with an issue/writeback scoreboard and a
// sequential bulk-clear engine that walks one entry per cycle.
module rv_regfile_sb #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 32,
  parameter int NRP     = 2,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                i_rf_clk,
  input  logic                i_rf_rstn,
  input  logic [NRP*AW-1:0]   i_rf_ra,
  output logic [NRP*XLEN-1:0] o_rf_rd,
  output logic [NRP-1:0]      o_rf_busy,
  input  logic                i_rf_we0,
  input  logic [AW-1:0]       i_rf_wa0,
  input  logic [XLEN-1:0]     i_rf_wd0,
  input  logic                i_rf_we1,
  input  logic [AW-1:0]       i_rf_wa1,
  input  logic [XLEN-1:0]     i_rf_wd1,
  input  logic                i_rf_iss_valid,
  input  logic [AW-1:0]       i_rf_iss_addr,
  input  logic                i_rf_clr_req,
  output logic                o_rf_clr_busy,
  output logic                o_rf_clr_done
);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_cnt;
  logic            r_clr_done, w_clr_done_nxt;
  logic [XLEN-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_busy;

  logic            w_idle, w_clr_last;
  logic            w_wr0, w_wr1, w_iss, w_byp_en;
  logic [AW-1:0]   w_ra;
  logic [XLEN-1:0] w_rdat;

  assign w_idle     = (r_state == S_IDLE);
  assign w_clr_last = (r_cnt == AW'(DEPTH - 1));

  // Entry 0 is read-only when hardwired; gating here keeps it out of both
  // storage and the scoreboard, so no read-side override is needed.
  assign w_wr0 = i_rf_we0 && !((ZERO_R0 != 0) && (i_rf_wa0 == '0));
  assign w_wr1 = i_rf_we1 && !((ZERO_R0 != 0) && (i_rf_wa1 == '0));
  assign w_iss = i_rf_iss_valid && !((ZERO_R0 != 0) && (i_rf_iss_addr == '0));

  // Forwarding is suppressed during reset so the outputs read as zero.
  assign w_byp_en = (BYPASS != 0) && w_idle && i_rf_rstn;

  always_comb begin
    w_state_nxt    = r_state;
    w_clr_done_nxt = 1'b0;
    o_rf_clr_busy  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_rf_clr_req) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        o_rf_clr_busy = 1'b1;
        if (w_clr_last) begin
          w_state_nxt    = S_IDLE;
          w_clr_done_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_rf_clk or negedge i_rf_rstn) begin
    if (!i_rf_rstn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_clr_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_done <= w_clr_done_nxt;
      r_cnt      <= ((r_state == S_CLEAR) && !w_clr_last) ? r_cnt + AW'(1) : '0;
    end
  end

  assign o_rf_clr_done = r_clr_done;

  // Later assignments win: port 1 over port 0, and a new issue over a
  // same-cycle writeback clearing the busy bit.
  always_ff @(posedge i_rf_clk or negedge i_rf_rstn) begin
    if (!i_rf_rstn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_busy <= '0;
    end else if (r_state == S_CLEAR) begin
      r_mem[r_cnt]  <= '0;
      r_busy[r_cnt] <= 1'b0;
    end else begin
      if (w_wr0) r_mem[i_rf_wa0] <= i_rf_wd0;
      if (w_wr1) r_mem[i_rf_wa1] <= i_rf_wd1;
      if (w_wr0) r_busy[i_rf_wa0] <= 1'b0;
      if (w_wr1) r_busy[i_rf_wa1] <= 1'b0;
      if (w_iss) r_busy[i_rf_iss_addr] <= 1'b1;
    end
  end

  always_comb begin
    o_rf_rd   = '0;
    o_rf_busy = '0;
    w_ra      = '0;
    w_rdat    = '0;
    for (int k = 0; k < NRP; k++) begin
      w_ra   = i_rf_ra[k*AW +: AW];
      w_rdat = r_mem[w_ra];
      if (w_byp_en && w_wr0 && (i_rf_wa0 == w_ra)) w_rdat = i_rf_wd0;
      if (w_byp_en && w_wr1 && (i_rf_wa1 == w_ra)) w_rdat = i_rf_wd1;
      o_rf_rd[k*XLEN +: XLEN] = w_rdat;
      o_rf_busy[k]            = r_busy[w_ra];
    end
  end

endmodule

// File: tb/tb_rv_regfile_sb.sv
// Bench for rv_regfile_sb: directed vector table, clear/reset sequences,
// randomized traffic against a reference model, and a 64-bit variant.
module tb_rv_regfile_sb;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // Default configuration instance
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  busy;
  logic        we0, we1, iss_v, clr_req, clr_busy, clr_done;
  logic [4:0]  wa0, wa1, iss_a;
  logic [31:0] wd0, wd1;
  logic [31:0] rd0, rd1;
  assign rd0 = rd[31:0];
  assign rd1 = rd[63:32];

  rv_regfile_sb dut (
    .i_rf_clk(clk), .i_rf_rstn(rstn), .i_rf_ra(ra), .o_rf_rd(rd), .o_rf_busy(busy),
    .i_rf_we0(we0), .i_rf_wa0(wa0), .i_rf_wd0(wd0),
    .i_rf_we1(we1), .i_rf_wa1(wa1), .i_rf_wd1(wd1),
    .i_rf_iss_valid(iss_v), .i_rf_iss_addr(iss_a), .i_rf_clr_req(clr_req),
    .o_rf_clr_busy(clr_busy), .o_rf_clr_done(clr_done)
  );

  // Wide, 3-port, no-forwarding, writable-x0 instance
  logic [11:0]  b_ra;
  logic [191:0] b_rd;
  logic [2:0]   b_busy;
  logic         b_we0, b_we1, b_iss_v, b_clr_req, b_clr_busy, b_clr_done;
  logic [3:0]   b_wa0, b_wa1, b_iss_a;
  logic [63:0]  b_wd0, b_wd1;

  rv_regfile_sb #(.XLEN(64), .DEPTH(16), .NRP(3), .ZERO_R0(0), .BYPASS(0)) dut2 (
    .i_rf_clk(clk), .i_rf_rstn(rstn), .i_rf_ra(b_ra), .o_rf_rd(b_rd), .o_rf_busy(b_busy),
    .i_rf_we0(b_we0), .i_rf_wa0(b_wa0), .i_rf_wd0(b_wd0),
    .i_rf_we1(b_we1), .i_rf_wa1(b_wa1), .i_rf_wd1(b_wd1),
    .i_rf_iss_valid(b_iss_v), .i_rf_iss_addr(b_iss_a), .i_rf_clr_req(b_clr_req),
    .o_rf_clr_busy(b_clr_busy), .o_rf_clr_done(b_clr_done)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    iss_v = 1'b0; iss_a = '0; clr_req = 1'b0;
  endtask

  // Reference model: architectural contents and scoreboard of the default instance
  logic [31:0] m_mem [32];
  logic        m_busy [32];

  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [31:0] v;
    if (a == 5'd0) return 32'd0;
    v = m_mem[a];
    if (we0 && wa0 == a) v = wd0;
    if (we1 && wa1 == a) v = wd1;
    return v;
  endfunction

  task automatic m_commit();
    if (we0 && wa0 != 5'd0) m_mem[wa0] = wd0;
    if (we1 && wa1 != 5'd0) m_mem[wa1] = wd1;
    if (we0) m_busy[wa0] = 1'b0;
    if (we1) m_busy[wa1] = 1'b0;
    if (iss_v && iss_a != 5'd0) m_busy[iss_a] = 1'b1;
  endtask

  task automatic m_zero();
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  typedef struct {
    logic        we0; logic [4:0] wa0; logic [31:0] wd0;
    logic        we1; logic [4:0] wa1; logic [31:0] wd1;
    logic        iv;  logic [4:0] ia;
    logic [4:0]  ra0; logic [4:0] ra1;
    logic [31:0] e0;  logic [31:0] e1;
    logic        eb0; logic       eb1;
  } vec_t;

  vec_t tv [9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    int blen;
    logic [4:0] r0, r1;

    // Forwarding, port priority, x0, and scoreboard set/clear/collision
    tv[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
    tv[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
    tv[2] = '{1'b1, 5'd7, 32'h11,       1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd7, 32'h22,       32'h22,       1'b0, 1'b0};
    tv[3] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 5'd0, 32'h22,       32'h0,        1'b0, 1'b0};
    tv[4] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 5'd0, 5'd3, 32'h0,        32'h0,        1'b0, 1'b0};
    tv[5] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 5'd7, 5'd3, 32'h22,       32'h33,       1'b0, 1'b1};
    tv[6] = '{1'b1, 5'd3, 32'h44,       1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 5'd5, 5'd3, 32'hDEADBEEF, 32'h44,       1'b0, 1'b0};
    tv[7] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd0, 5'd0, 5'd3, 32'h0,        32'h44,       1'b0, 1'b1};
    tv[8] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 5'd3, 32'h0,        32'h44,       1'b0, 1'b1};

    idle_in();
    ra = '0;
    b_ra = '0; b_we0 = 0; b_wa0 = '0; b_wd0 = '0; b_we1 = 0; b_wa1 = '0; b_wd1 = '0;
    b_iss_v = 0; b_iss_a = '0; b_clr_req = 0;

    // Reset: outputs zero, inputs ignored
    repeat (2) @(negedge clk);
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h12345678; ra = {5'd5, 5'd5};
    #1;
    chk("rst_rd0", 64'(rd0), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_clr_busy", 64'(clr_busy), 64'h0);
    chk("rst_clr_done", 64'(clr_done), 64'h0);
    chk("rst_b_rd", 64'(b_rd[63:0]), 64'h0);
    @(negedge clk);
    idle_in();
    rstn = 1'b1;
    cyc();

    for (int i = 0; i < 9; i++) begin
      we0 = tv[i].we0; wa0 = tv[i].wa0; wd0 = tv[i].wd0;
      we1 = tv[i].we1; wa1 = tv[i].wa1; wd1 = tv[i].wd1;
      iss_v = tv[i].iv; iss_a = tv[i].ia;
      ra = {tv[i].ra1, tv[i].ra0};
      @(negedge clk);
      chk($sformatf("vec%0d_rd0", i), 64'(rd0), 64'(tv[i].e0));
      chk($sformatf("vec%0d_rd1", i), 64'(rd1), 64'(tv[i].e1));
      chk($sformatf("vec%0d_busy0", i), 64'(busy[0]), 64'(tv[i].eb0));
      chk($sformatf("vec%0d_busy1", i), 64'(busy[1]), 64'(tv[i].eb1));
      cyc();
    end
    idle_in();

    // Fill every entry, issuing the previous one, so the clear has work to do
    m_zero();
    m_mem[5] = 32'hDEADBEEF; m_mem[7] = 32'h22; m_mem[3] = 32'h44; m_busy[3] = 1'b1;
    for (int i = 0; i < 32; i++) begin
      we0 = 1'b1; wa0 = 5'(i); wd0 = $urandom | 32'h1;
      iss_v = (i > 0); iss_a = 5'(i - 1);
      m_commit();
      cyc();
    end
    idle_in();
    iss_v = 1'b1; iss_a = 5'd31;
    m_commit();
    cyc();
    idle_in();
    ra = {5'd31, 5'd17};
    @(negedge clk);
    chk("fill_rd17", 64'(rd0), 64'(m_mem[17]));
    chk("fill_busy31", 64'(busy[1]), 64'h1);

    // Bulk clear: DEPTH busy cycles, old values visible until their turn
    cyc();
    clr_req = 1'b1;
    @(negedge clk);
    chk("clr_pre_busy", 64'(clr_busy), 64'h0);
    cyc();
    clr_req = 1'b0;
    for (int c = 0; c < 32; c++) begin
      if (c == 3) begin
        we0 = 1'b1; wa0 = 5'd1; wd0 = 32'h1111;
        iss_v = 1'b1; iss_a = 5'd2; clr_req = 1'b1;
        ra = {5'd20, 5'd1};
      end else begin
        idle_in();
        ra = {5'(c), 5'(c)};
      end
      @(negedge clk);
      chk($sformatf("clr%0d_busy", c), 64'(clr_busy), 64'h1);
      chk($sformatf("clr%0d_done", c), 64'(clr_done), 64'h0);
      if (c == 3) begin
        chk("clr_nobyp_x1", 64'(rd0), 64'h0);
        chk("clr_old_x20", 64'(rd1), 64'(m_mem[20]));
      end else begin
        chk($sformatf("clr%0d_old", c), 64'(rd0), (c == 0) ? 64'h0 : 64'(m_mem[c]));
        chk($sformatf("clr%0d_oldbusy", c), 64'(busy[0]), 64'(m_busy[c]));
      end
      cyc();
    end
    idle_in();
    @(negedge clk);
    chk("clr_end_busy", 64'(clr_busy), 64'h0);
    chk("clr_end_done", 64'(clr_done), 64'h1);
    cyc();
    @(negedge clk);
    chk("clr_done_pulse", 64'(clr_done), 64'h0);
    m_zero();
    seen = 0;
    for (int i = 0; i < 32; i++) begin
      ra = {5'(31 - i), 5'(i)};
      @(negedge clk);
      if (rd0 != 0 || rd1 != 0 || busy != 0) seen++;
    end
    chk("clr_all_zero", 64'(seen), 64'h0);

    // Reset in the middle of a clear
    cyc();
    we0 = 1'b1; wa0 = 5'd20; wd0 = 32'hABCD1234;
    cyc();
    idle_in(); iss_v = 1'b1; iss_a = 5'd25;
    cyc();
    idle_in(); clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    repeat (10) cyc();
    ra = {5'd25, 5'd20};
    @(negedge clk);
    chk("mid_pre_rd20", 64'(rd0), 64'hABCD1234);
    chk("mid_pre_busy25", 64'(busy[1]), 64'h1);
    chk("mid_pre_clr_busy", 64'(clr_busy), 64'h1);
    #1;
    rstn = 1'b0;
    we0 = 1'b1; wa0 = 5'd20; wd0 = 32'h5555;
    #1;
    chk("mid_rst_rd20", 64'(rd0), 64'h0);
    chk("mid_rst_busy25", 64'(busy[1]), 64'h0);
    chk("mid_rst_clr_busy", 64'(clr_busy), 64'h0);
    chk("mid_rst_clr_done", 64'(clr_done), 64'h0);
    cyc();
    chk("mid_rst_hold_rd20", 64'(rd0), 64'h0);
    @(negedge clk);
    rstn = 1'b1;
    we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h77;
    cyc();
    idle_in();
    ra = {5'd20, 5'd4};
    @(negedge clk);
    chk("first_wr_x4", 64'(rd0), 64'h77);
    chk("rst_wr_lost_x20", 64'(rd1), 64'h0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (clr_done || clr_busy) seen++;
    end
    chk("mid_rst_no_done", 64'(seen), 64'h0);
    m_zero();
    m_mem[4] = 32'h77;

    // Randomized traffic against the reference model
    cyc();
    for (int n = 0; n < 400; n++) begin
      we0 = 1'($urandom_range(0, 1)); wa0 = 5'($urandom); wd0 = $urandom;
      we1 = 1'($urandom_range(0, 1));
      wa1 = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom); wd1 = $urandom;
      iss_v = 1'($urandom_range(0, 1));
      iss_a = ($urandom_range(0, 3) == 0) ? wa1 : 5'($urandom);
      r0 = ($urandom_range(0, 2) == 0) ? wa0 : 5'($urandom);
      r1 = ($urandom_range(0, 2) == 0) ? wa1 : 5'($urandom);
      ra = {r1, r0};
      @(negedge clk);
      chk("rnd_rd0", 64'(rd0), 64'(m_read(r0)));
      chk("rnd_rd1", 64'(rd1), 64'(m_read(r1)));
      chk("rnd_busy0", 64'(busy[0]), 64'(m_busy[r0]));
      chk("rnd_busy1", 64'(busy[1]), 64'(m_busy[r1]));
      m_commit();
      cyc();
    end
    idle_in();

    // Wide variant: x0 writable, no forwarding, 16-cycle clear
    b_we0 = 1'b1; b_wa0 = 4'd0; b_wd0 = 64'h0123456789ABCDEF;
    b_ra = {4'd0, 4'd0, 4'd0};
    @(negedge clk);
    chk("b_nofwd_x0", b_rd[63:0], 64'h0);
    cyc();
    b_we0 = 1'b1; b_wa0 = 4'd3; b_wd0 = 64'h1;
    b_we1 = 1'b1; b_wa1 = 4'd3; b_wd1 = 64'h2;
    b_ra = {4'd0, 4'd3, 4'd0};
    @(negedge clk);
    chk("b_x0_rd0", b_rd[63:0], 64'h0123456789ABCDEF);
    chk("b_x0_rd2", b_rd[191:128], 64'h0123456789ABCDEF);
    chk("b_nofwd_x3", b_rd[127:64], 64'h0);
    cyc();
    b_we0 = 1'b0; b_we1 = 1'b0;
    b_iss_v = 1'b1; b_iss_a = 4'd0;
    @(negedge clk);
    chk("b_x3_port1", b_rd[127:64], 64'h2);
    cyc();
    b_iss_v = 1'b0;
    @(negedge clk);
    chk("b_busy_x0", 64'(b_busy), 64'h5);
    cyc();
    b_clr_req = 1'b1;
    cyc();
    b_clr_req = 1'b0;
    blen = 0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (b_clr_busy) blen++;
      if (b_clr_done) begin
        seen = 1;
        break;
      end
      cyc();
    end
    chk("b_clr_len", 64'(blen), 64'd16);
    chk("b_clr_done_seen", 64'(seen), 64'h1);
    chk("b_clr_x0", b_rd[63:0], 64'h0);
    chk("b_clr_x3", b_rd[127:64], 64'h0);
    chk("b_clr_busy_bits", 64'(b_busy), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
